updown_counter_mod: RTL and testbench
=====================================

Name: updown_counter_mod

Overview:
- Parametrised up/down counter; successor to the fixed 4-bit up/down counter.
- Adds generic width, programmable modulus, count enable, parallel load, wrap/saturate mode, terminal-count pulse and sticky overflow flag.
- Used directly by Nexys 4 training designs (digit counters, timers) and as a building block for cascaded decade counters.

Parameters:
- WIDTH, 4, counter width in bits (2..32).
- MOD_MAX, 2**WIDTH-1, highest legal count value; range is 0..MOD_MAX; must be <= 2**WIDTH-1.
- PRESCALE_DIV, 100000000, clk cycles per count tick; used only when PRESCALER_EN is defined; must be >= 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; a step occurs only on edges where en=1 (and tick=1 if the prescaler is built).
- up_down_sw  input  1  1 = count up, 0 = count down.
- sat_mode  input  1  1 = saturate at the bounds, 0 = wrap around.
- load  input  1  synchronous parallel load.
- load_data  input  WIDTH  value to load.
- clr_flags  input  1  clears ovf_sticky.
- count  output  WIDTH  registered count value.
- tc  output  1  registered terminal-count pulse.
- ovf_sticky  output  1  registered sticky boundary-event flag.

Behaviour:
- Reset and clock: reset is synchronous, active-high; clock is clk. On reset: count=0, tc=0, ovf_sticky=0, prescaler=0.
- Priority per rising edge: reset > load > step > hold.
- Load:
  - count <= min(load_data, MOD_MAX); values above MOD_MAX clamp to MOD_MAX.
  - tc <= 0; ovf_sticky is unchanged; no step occurs on a load edge, even if en=1.
- Step (en=1, load=0):
  - Up, count<MOD_MAX: count+1.
  - Up, count==MOD_MAX: wrap mode gives 0; sat mode holds MOD_MAX.
  - Down, count>0: count-1.
  - Down, count==0: wrap mode gives MOD_MAX; sat mode holds 0.
- Boundary event: a step attempted at the bound in the current direction, in either mode.
  - tc <= 1 for exactly one cycle, visible together with the new count.
  - ovf_sticky <= 1.
  - tc <= 0 on every other edge.
- Latency: one edge from en/load to the count update; tc is aligned with the count it describes.
- up_down_sw and sat_mode are sampled on each edge; a change takes effect on that edge with no pipeline.
- clr_flags=1 clears ovf_sticky. If a boundary event and clr_flags occur on the same edge, set wins (ovf_sticky=1).
- Continuous en=1 at a saturated bound gives a tc pulse every enabled edge.
- Arithmetic: WIDTH-bit unsigned; wrap targets come from the MOD_MAX comparison, never natural overflow, except when MOD_MAX=2**WIDTH-1 (results identical).
- Reset mid-count overrides load/en on the same edge; the next edge counts from 0.

Optional Feature:
- Macro: PRESCALER_EN.
- Defined:
  - Instantiates a tick generator that produces a 1-cycle tick every PRESCALE_DIV clk cycles.
  - The effective step enable is en & tick.
  - The prescaler free-runs, is cleared by reset, and is not cleared by load.
- Undefined: no prescaler logic; en is used directly and PRESCALE_DIV is ignored.

Decomposition:
- Shared package counter_pkg:
  - direction constants DIR_UP=1, DIR_DOWN=0.
  - mode constants MODE_WRAP=0, MODE_SAT=1.
  - a function returning clog2 for the prescaler width.
- Sub-module counter_tick_gen (parameter DIV; ports clk, reset, tick): only instantiated under PRESCALER_EN. It is reusable by other Nexys 4 blocks.

Test Plan (WIDTH=4, MOD_MAX=9, PRESCALER_EN undefined unless stated):
- Reset, then en=1, up, wrap for 12 edges -> count 1..9,0,1,2; tc high only with count=0; ovf_sticky=1 afterwards.
- From 0, en=1, down, sat for 3 edges -> count stays 0; tc high on all 3 edges; clr_flags pulse -> ovf_sticky=0.
- load=1, load_data=13, en=1 -> count=9, tc=0; next edge up/wrap -> count=0, tc=1.
- count=5, toggle up_down_sw every edge with en=1 -> sequence 6,5,6,5; tc never asserted. Then en=0 -> count holds.
- count=7, reset=1 with load=1 and en=1 on the same edge -> count=0, tc=0, ovf_sticky=0. Boundary event with simultaneous clr_flags -> ovf_sticky=1.
- PRESCALER_EN defined, PRESCALE_DIV=4, en=1, up -> count increments once every 4 clk edges; first increment on the 4th edge after reset release.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter family.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Bits needed to hold 0..v-1; never less than 1 so a register is always declarable.
    function automatic int unsigned cnt_clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/counter_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clk cycles, first tick on the DIV-th edge
// after reset release.
module counter_tick_gen
    import counter_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned     LP_W    = cnt_clog2(DIV);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(DIV - 1);
    localparam logic [LP_W-1:0] LP_ONE  = LP_W'(1);

    logic [LP_W-1:0] r_div;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
        end else if (r_div == LP_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + LP_ONE;
        end
    end

    assign tick = (r_div == LP_LAST);

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with modulus, load, wrap/saturate, tc pulse and sticky flag.
// Define PRESCALER_EN to gate stepping with a tick every PRESCALE_DIV clk cycles.
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH        = 4,
    parameter longint unsigned MOD_MAX      = (64'd1 << WIDTH) - 64'd1,
    parameter int unsigned     PRESCALE_DIV = 100000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down_sw,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf_sticky
);

    localparam logic [WIDTH-1:0] LP_MAX = MOD_MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("updown_counter_mod: WIDTH out of range");
    end
    if (MOD_MAX > (64'd1 << WIDTH) - 64'd1) begin : g_bad_mod
        $error("updown_counter_mod: MOD_MAX does not fit WIDTH");
    end
    if (PRESCALE_DIV < 2) begin : g_bad_div
        $error("updown_counter_mod: PRESCALE_DIV must be >= 2");
    end

    logic             w_tick;
    logic             w_step;
    logic             w_at_bound;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

`ifdef PRESCALER_EN
    counter_tick_gen #(
        .DIV (PRESCALE_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );
`else
    assign w_tick = 1'b1;
`endif

    assign w_step = en & w_tick;

    // Bound is relative to the current direction; wrap targets come from MOD_MAX, not overflow.
    always_comb begin
        w_at_bound = 1'b0;
        w_next     = r_count;
        if (up_down_sw == DIR_UP) begin
            w_at_bound = (r_count == LP_MAX);
            if (!w_at_bound) begin
                w_next = r_count + LP_ONE;
            end else if (sat_mode == MODE_WRAP) begin
                w_next = '0;
            end
        end else begin
            w_at_bound = (r_count == '0);
            if (!w_at_bound) begin
                w_next = r_count - LP_ONE;
            end else if (sat_mode == MODE_WRAP) begin
                w_next = LP_MAX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (load) begin
            r_count <= (load_data > LP_MAX) ? LP_MAX : load_data;
            r_tc    <= 1'b0;
            if (clr_flags) r_ovf <= 1'b0;
        end else if (w_step) begin
            r_count <= w_next;
            r_tc    <= w_at_bound;
            // A boundary event on the same edge as clr_flags leaves the flag set.
            if (w_at_bound)     r_ovf <= 1'b1;
            else if (clr_flags) r_ovf <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (clr_flags) r_ovf <= 1'b0;
        end
    end

    assign count      = r_count;
    assign tc         = r_tc;
    assign ovf_sticky = r_ovf;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Self-checking bench for updown_counter_mod (WIDTH=4, MOD_MAX=9): directed steps then random.
module tb_updown_counter_mod;

    localparam int W    = 4;
    localparam int MAXV = 9;
    localparam int DIV  = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic         up_down_sw = 1'b1;
    logic         sat_mode = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         clr_flags = 1'b0;
    logic [W-1:0] count;
    logic         tc;
    logic         ovf_sticky;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state
    int m_count = 0;
    int m_tc    = 0;
    int m_ovf   = 0;
    int m_edges = 0;

    updown_counter_mod #(
        .WIDTH        (W),
        .MOD_MAX      (MAXV),
        .PRESCALE_DIV (DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .up_down_sw (up_down_sw),
        .sat_mode   (sat_mode),
        .load       (load),
        .load_data  (load_data),
        .clr_flags  (clr_flags),
        .count      (count),
        .tc         (tc),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    endtask

    task automatic model_edge(input int e, ud, sm, ld, ldd, clr, rst);
        int tick;
        int bnd;
        if (rst != 0) begin
            m_count = 0; m_tc = 0; m_ovf = 0; m_edges = 0;
            return;
        end
`ifdef PRESCALER_EN
        tick = ((m_edges % DIV) == DIV - 1) ? 1 : 0;
`else
        tick = 1;
`endif
        m_edges++;
        if (ld != 0) begin
            m_count = (ldd > MAXV) ? MAXV : ldd;
            m_tc    = 0;
            if (clr != 0) m_ovf = 0;
        end else if (e != 0 && tick != 0) begin
            if (ud != 0) begin
                bnd     = (m_count + 1 > MAXV) ? 1 : 0;
                m_count = (sm != 0) ? ((bnd != 0) ? MAXV : m_count + 1)
                                    : (m_count + 1) % (MAXV + 1);
            end else begin
                bnd     = (m_count == 0) ? 1 : 0;
                m_count = (sm != 0) ? ((bnd != 0) ? 0 : m_count - 1)
                                    : (m_count + MAXV) % (MAXV + 1);
            end
            m_tc = bnd;
            if (bnd != 0)      m_ovf = 1;
            else if (clr != 0) m_ovf = 0;
        end else begin
            m_tc = 0;
            if (clr != 0) m_ovf = 0;
        end
    endtask

    // Drive inputs, take one rising edge, update the model, check #1 after the edge.
    task automatic step(input string tag, input int e, ud, sm, ld, ldd, clr, rst);
        en = e[0]; up_down_sw = ud[0]; sat_mode = sm[0]; load = ld[0];
        load_data = W'(ldd); clr_flags = clr[0]; reset = rst[0];
        @(posedge clk);
        model_edge(e, ud, sm, ld, ldd, clr, rst);
        #1;
        check({tag, ".count"}, int'(count), m_count);
        check({tag, ".tc"}, int'(tc), m_tc);
        check({tag, ".ovf"}, int'(ovf_sticky), m_ovf);
    endtask

    initial begin
        #2;
        step("reset", 0, 1, 0, 0, 0, 0, 1);
        check("reset.count0", int'(count), 0);
        // Up/wrap 12 edges: 1..9,0,1,2 with tc only at 0
        for (int i = 0; i < 12; i++) step("up_wrap", 1, 1, 0, 0, 0, 0, 0);
        // Down/sat at 0: tc every edge, then clear flag
        step("to_zero", 0, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("down_sat", 1, 0, 1, 0, 0, 0, 0);
        step("clr", 0, 0, 1, 0, 0, 1, 0);
        // Load above MOD_MAX clamps, no step on load edge; then wrap from 9
        step("load13", 1, 1, 0, 1, 13, 0, 0);
        step("wrap9", 1, 1, 0, 0, 0, 0, 0);
        // Direction toggle from 5
        step("load5", 0, 1, 0, 1, 5, 0, 0);
        for (int i = 0; i < 4; i++) step("toggle", 1, (i % 2 == 0) ? 1 : 0, 0, 0, 0, 0, 0);
        step("hold", 0, 1, 0, 0, 0, 0, 0);
        step("hold2", 0, 0, 1, 0, 0, 0, 0);
        // Reset beats load/en
        step("load7", 0, 1, 0, 1, 7, 0, 0);
        step("rst_ovr", 1, 1, 0, 1, 3, 0, 1);
        step("after_rst", 1, 1, 0, 0, 0, 0, 0);
        // Boundary event with simultaneous clr keeps flag set
        step("load0", 0, 1, 0, 1, 0, 0, 0);
        step("bnd_clr", 1, 0, 0, 0, 0, 1, 0);
        step("ld_max", 0, 1, 1, 1, 9, 0, 0);
        step("sat_up", 1, 1, 1, 0, 0, 1, 0);
        step("sat_up2", 1, 1, 1, 0, 0, 0, 0);
        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 3) != 0) ? 1 : 0,
                 int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 1 : 0,
                 int'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) == 0) ? 1 : 0,
                 ($urandom_range(0, 39) == 0) ? 1 : 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
